// File: rtl/dma_arbiter_pkg.sv
// dma_arbiter_pkg
//   Shared definitions for the DMA bus arbiter: the arbitration state
//   encoding and the default values of the block parameters.
package dma_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_CPU = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_GRANTED  = 3'd3,
    ST_RELEASE  = 3'd4
  } arb_state_t;

  localparam int          DEF_PAGE_WIDTH    = 4;
  localparam int          DEF_GRANT_DELAY   = 2;
  localparam int          DEF_RELEASE_DELAY = 1;
  localparam int          DEF_TIMEOUT_WIDTH = 16;
  localparam logic [15:0] DEF_MAX_HOLD      = 16'hFFFF;

endpackage

// File: rtl/dma_bus_arbiter_if.sv
// dma_bus_arbiter_if
//   Bus-ownership handshake between the CPU, the 8237 DMA controller and
//   the arbiter.
//   hold_request     : HRQ from the DMA controller
//   hold_acknowledge : HLDA to the DMA controller
//   cpu_bus_idle     : CPU is in T4/Ti (no bus cycle in progress)
//   cpu_lock_n       : CPU LOCK, active low, blocks a grant
//   cpu_bus_release  : tri-states the CPU address/data/control drivers
//   dma_acknowledge  : DACK[3:0] from the DMA controller, active high
//   modport master   : the arbiter side
//   modport slave    : the CPU / DMA controller side
interface dma_bus_arbiter_if;
  logic       hold_request;
  logic       hold_acknowledge;
  logic       cpu_bus_idle;
  logic       cpu_lock_n;
  logic       cpu_bus_release;
  logic [3:0] dma_acknowledge;

  modport master (
    input  hold_request,
    input  cpu_bus_idle,
    input  cpu_lock_n,
    input  dma_acknowledge,
    output hold_acknowledge,
    output cpu_bus_release
  );

  modport slave (
    output hold_request,
    output cpu_bus_idle,
    output cpu_lock_n,
    output dma_acknowledge,
    input  hold_acknowledge,
    input  cpu_bus_release
  );
endinterface

// File: rtl/dma_page_registers.sv
// dma_page_registers
//   Four channel page registers supplying the address bits above the DMA
//   controller's 16-bit address.
//   clock, reset_n   : clock, asynchronous active-low reset
//   page_write       : write strobe for page_q[page_select]
//   page_select      : channel index for write and readback
//   page_data_in     : write data
//   dma_acknowledge  : DACK[3:0], selects the page driven on the bus
//   page_data_out    : combinational readback of page_q[page_select]
//   dma_high_address : page of the lowest-index acknowledged channel, else 0
module dma_page_registers
  import dma_arbiter_pkg::*;
#(
  parameter int PAGE_WIDTH = DEF_PAGE_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  page_write,
  input  logic [1:0]            page_select,
  input  logic [PAGE_WIDTH-1:0] page_data_in,
  input  logic [3:0]            dma_acknowledge,
  output logic [PAGE_WIDTH-1:0] page_data_out,
  output logic [PAGE_WIDTH-1:0] dma_high_address
);

  logic [PAGE_WIDTH-1:0] page_q [4];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) page_q[i] <= '0;
    end else if (page_write) begin
      page_q[page_select] <= page_data_in;
    end
  end

  assign page_data_out = page_q[page_select];

  // Scanning from the top down lets the lowest asserted DACK bit win when
  // more than one is (abnormally) active.
  always_comb begin
    dma_high_address = '0;
    for (int i = 3; i >= 0; i--) begin
      if (dma_acknowledge[i]) dma_high_address = page_q[i];
    end
  end

endmodule

// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter
//   Hands the system bus from the CPU to the DMA controller: HRQ becomes
//   HLDA only after the CPU is idle and unlocked and its drivers have been
//   released for GRANT_DELAY cycles. Also hosts the page registers and a
//   watchdog that flags overly long DMA tenures.
//   clock, reset_n   : clock, asynchronous active-low reset
//   bus              : handshake interface (master modport)
//   page_write/page_select/page_data_in/page_data_out : page register port
//   dma_high_address : page of the acknowledged channel
//   hold_timeout     : sticky watchdog flag
//   clear_timeout    : synchronous clear of hold_timeout (set wins)
module dma_bus_arbiter
  import dma_arbiter_pkg::*;
#(
  parameter int                       PAGE_WIDTH    = DEF_PAGE_WIDTH,
  parameter int                       GRANT_DELAY   = DEF_GRANT_DELAY,
  parameter int                       RELEASE_DELAY = DEF_RELEASE_DELAY,
  parameter int                       TIMEOUT_WIDTH = DEF_TIMEOUT_WIDTH,
  parameter logic [TIMEOUT_WIDTH-1:0] MAX_HOLD      = DEF_MAX_HOLD
) (
  input  logic                  clock,
  input  logic                  reset_n,
  dma_bus_arbiter_if.master     bus,
  input  logic                  page_write,
  input  logic [1:0]            page_select,
  input  logic [PAGE_WIDTH-1:0] page_data_in,
  output logic [PAGE_WIDTH-1:0] page_data_out,
  output logic [PAGE_WIDTH-1:0] dma_high_address,
  output logic                  hold_timeout,
  input  logic                  clear_timeout
);

  localparam int MAX_DELAY = (GRANT_DELAY > RELEASE_DELAY) ? GRANT_DELAY : RELEASE_DELAY;
  localparam int DLY_W     = $clog2(MAX_DELAY + 1);
  localparam logic [DLY_W-1:0] GRANT_LOAD   = DLY_W'(GRANT_DELAY);
  localparam logic [DLY_W-1:0] RELEASE_LOAD = DLY_W'(RELEASE_DELAY);
  localparam logic [DLY_W-1:0] DLY_LAST     = DLY_W'(1);

  arb_state_t               state_q, state_d;
  logic [DLY_W-1:0]         dly_q, dly_d;
  logic [TIMEOUT_WIDTH-1:0] wd_cnt_q, wd_cnt_d;
  logic                     timeout_q, timeout_d;
  logic                     wd_set;

  // State register plus the delay counter and watchdog that travel with it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      dly_q     <= '0;
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dly_q     <= dly_d;
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic. The delay counter holds the number of cycles left in
  // SETTLE/RELEASE, so the exit happens while it reads 1.
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.hold_request) state_d = ST_WAIT_CPU;
      end
      ST_WAIT_CPU: begin
        if (!bus.hold_request) begin
          state_d = ST_IDLE;
        end else if (bus.cpu_bus_idle && bus.cpu_lock_n) begin
          state_d = ST_SETTLE;
          dly_d   = GRANT_LOAD;
        end
      end
      ST_SETTLE: begin
        // A withdrawn request still has to unwind through RELEASE because
        // the CPU drivers are already off the bus.
        if (!bus.hold_request) begin
          state_d = ST_RELEASE;
          dly_d   = RELEASE_LOAD;
        end else if (dly_q == DLY_LAST) begin
          state_d = ST_GRANTED;
        end else begin
          dly_d = dly_q - 1'b1;
        end
      end
      ST_GRANTED: begin
        if (!bus.hold_request) begin
          state_d = ST_RELEASE;
          dly_d   = RELEASE_LOAD;
        end
      end
      ST_RELEASE: begin
        if (dly_q == DLY_LAST) state_d = ST_IDLE;
        else                   dly_d   = dly_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Watchdog: counts GRANTED cycles from zero on each new tenure. The set
  // term stays true once saturated so it keeps beating clear_timeout.
  always_comb begin
    wd_cnt_d  = wd_cnt_q;
    wd_set    = (state_q == ST_GRANTED) && (wd_cnt_q >= MAX_HOLD - 1'b1);
    if (state_d == ST_GRANTED && state_q != ST_GRANTED) begin
      wd_cnt_d = '0;
    end else if (state_q == ST_GRANTED && wd_cnt_q != MAX_HOLD) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
    timeout_d = timeout_q;
    if (wd_set)             timeout_d = 1'b1;
    else if (clear_timeout) timeout_d = 1'b0;
  end

  // Outputs decode straight from the state register.
  always_comb begin
    bus.cpu_bus_release  = (state_q == ST_SETTLE) || (state_q == ST_GRANTED) ||
                           (state_q == ST_RELEASE);
    bus.hold_acknowledge = (state_q == ST_GRANTED);
  end

  assign hold_timeout = timeout_q;

  dma_page_registers #(
    .PAGE_WIDTH(PAGE_WIDTH)
  ) u_pages (
    .clock           (clock),
    .reset_n         (reset_n),
    .page_write      (page_write),
    .page_select     (page_select),
    .page_data_in    (page_data_in),
    .dma_acknowledge (bus.dma_acknowledge),
    .page_data_out   (page_data_out),
    .dma_high_address(dma_high_address)
  );

endmodule

// File: tb/tb_dma_bus_arbiter.sv
module tb_dma_bus_arbiter;
  localparam int PW = 4;
  localparam int GD = 2;
  localparam int RD = 1;
  localparam int MH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dma_bus_arbiter_if bus_if ();
  logic          page_write = 1'b0;
  logic [1:0]    page_select = 2'd0;
  logic [PW-1:0] page_data_in = '0;
  logic [PW-1:0] page_data_out;
  logic [PW-1:0] dma_high_address;
  logic          hold_timeout;
  logic          clear_timeout = 1'b0;

  dma_bus_arbiter #(
    .PAGE_WIDTH(PW), .GRANT_DELAY(GD), .RELEASE_DELAY(RD),
    .TIMEOUT_WIDTH(16), .MAX_HOLD(16'd8)
  ) dut (
    .clock           (clk),
    .reset_n         (rst_n),
    .bus             (bus_if.master),
    .page_write      (page_write),
    .page_select     (page_select),
    .page_data_in    (page_data_in),
    .page_data_out   (page_data_out),
    .dma_high_address(dma_high_address),
    .hold_timeout    (hold_timeout),
    .clear_timeout   (clear_timeout)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference model, in terms of edge numbers: once the bus is taken at
  // edge E, HLDA is due at edge E+GD; a drop at edge Ef frees the bus at
  // edge Ef+RD.
  int            cyc = 0;
  bit            m_armed, m_busy, m_ack, m_to;
  int            m_grant_edge, m_rel_end, m_gcnt;
  logic [PW-1:0] m_page [4];

  task automatic model_reset();
    m_armed = 0; m_busy = 0; m_ack = 0; m_to = 0;
    m_grant_edge = -1; m_rel_end = -1; m_gcnt = 0;
    for (int i = 0; i < 4; i++) m_page[i] = '0;
  endtask

  task automatic model_edge();
    bit hr   = bus_if.hold_request;
    bit idle = bus_if.cpu_bus_idle;
    bit lk   = bus_if.cpu_lock_n;
    bit set_to = 0;
    if (m_ack) begin
      m_gcnt++;
      if (m_gcnt >= MH) set_to = 1;
    end
    if (set_to) m_to = 1;
    else if (clear_timeout) m_to = 0;
    if (page_write) m_page[page_select] = page_data_in;
    if (m_busy) begin
      if (m_rel_end >= 0) begin
        if (cyc == m_rel_end) begin m_busy = 0; m_rel_end = -1; end
      end else if (!hr) begin
        m_ack = 0; m_rel_end = cyc + RD;
      end else if (cyc == m_grant_edge) begin
        m_ack = 1; m_gcnt = 0;
      end
    end else if (m_armed) begin
      if (!hr) m_armed = 0;
      else if (idle && lk) begin m_armed = 0; m_busy = 1; m_grant_edge = cyc + GD; end
    end else if (hr) begin
      m_armed = 1;
    end
  endtask

  function automatic logic [PW-1:0] exp_high(input logic [3:0] dack);
    for (int i = 0; i < 4; i++) if (dack[i]) return m_page[i];
    return '0;
  endfunction

  task automatic compare_all();
    check_value("hlda",      bus_if.hold_acknowledge, m_ack);
    check_value("release",   bus_if.cpu_bus_release,  m_busy);
    check_value("timeout",   hold_timeout,            m_to);
    check_value("page_out",  page_data_out,           m_page[page_select]);
    check_value("high_addr", dma_high_address,        exp_high(bus_if.dma_acknowledge));
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    compare_all();
  endtask

  // Called 1ns after an edge: drops reset mid-cycle and checks that every
  // output is cleared before any clock edge arrives.
  task automatic reset_pulse();
    #3;
    rst_n = 1'b0;
    #1;
    check_value("rst_hlda",    bus_if.hold_acknowledge, 1'b0);
    check_value("rst_release", bus_if.cpu_bus_release,  1'b0);
    check_value("rst_timeout", hold_timeout,            1'b0);
    for (int s = 0; s < 4; s++) begin
      page_select = 2'(s);
      #1;
      check_value("rst_page", page_data_out, '0);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic set_bus(input bit hr, input bit idle, input bit lk);
    bus_if.hold_request = hr;
    bus_if.cpu_bus_idle = idle;
    bus_if.cpu_lock_n   = lk;
  endtask

  initial begin
    set_bus(0, 1, 1);
    bus_if.dma_acknowledge = 4'b0000;
    model_reset();
    #1;
    check_value("reset_hlda",    bus_if.hold_acknowledge, 1'b0);
    check_value("reset_release", bus_if.cpu_bus_release,  1'b0);
    check_value("reset_timeout", hold_timeout,            1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic grant and release.
    set_bus(1, 1, 1);
    step();
    check_value("e1_release", bus_if.cpu_bus_release, 1'b0);
    step();
    check_value("e2_release", bus_if.cpu_bus_release, 1'b1);
    check_value("e2_hlda", bus_if.hold_acknowledge, 1'b0);
    step();
    check_value("e3_hlda", bus_if.hold_acknowledge, 1'b0);
    step();
    check_value("e4_hlda", bus_if.hold_acknowledge, 1'b1);
    repeat (2) step();
    bus_if.hold_request = 1'b0;
    step();
    check_value("drop_hlda", bus_if.hold_acknowledge, 1'b0);
    check_value("drop_release", bus_if.cpu_bus_release, 1'b1);
    step();
    check_value("released", bus_if.cpu_bus_release, 1'b0);
    step();

    // CPU busy for five extra WAIT_CPU cycles.
    set_bus(1, 0, 1);
    repeat (6) step();
    bus_if.cpu_bus_idle = 1'b1;
    repeat (2) step();
    check_value("busy_hlda_early", bus_if.hold_acknowledge, 1'b0);
    step();
    check_value("busy_hlda", bus_if.hold_acknowledge, 1'b1);
    bus_if.hold_request = 1'b0;
    repeat (3) step();

    // Locked CPU blocks the grant.
    set_bus(1, 1, 0);
    repeat (4) step();
    check_value("lock_release", bus_if.cpu_bus_release, 1'b0);
    bus_if.cpu_lock_n = 1'b1;
    repeat (3) step();
    check_value("lock_hlda", bus_if.hold_acknowledge, 1'b1);
    bus_if.hold_request = 1'b0;
    repeat (3) step();

    // Request withdrawn in WAIT_CPU, then in SETTLE.
    set_bus(1, 0, 1);
    repeat (3) step();
    bus_if.hold_request = 1'b0;
    repeat (3) step();
    check_value("wait_drop_release", bus_if.cpu_bus_release, 1'b0);
    set_bus(1, 1, 1);
    repeat (2) step();
    bus_if.hold_request = 1'b0;
    step();
    check_value("settle_drop_hlda", bus_if.hold_acknowledge, 1'b0);
    check_value("settle_drop_release", bus_if.cpu_bus_release, 1'b1);
    step();
    check_value("settle_drop_end", bus_if.cpu_bus_release, 1'b0);
    step();

    // Page registers and DACK select.
    page_write = 1'b1; page_select = 2'd2; page_data_in = 4'hA;
    #1;
    check_value("page_nobypass", page_data_out, m_page[2]);
    step();
    page_select = 2'd3; page_data_in = 4'h5;
    step();
    page_write = 1'b0;
    bus_if.dma_acknowledge = 4'b0100; #1;
    check_value("dack2_page", dma_high_address, 4'hA);
    bus_if.dma_acknowledge = 4'b1000; #1;
    check_value("dack3_page", dma_high_address, 4'h5);
    bus_if.dma_acknowledge = 4'b0000; #1;
    check_value("dack_none", dma_high_address, 4'h0);
    step();

    // Watchdog: eight GRANTED cycles raise the flag.
    set_bus(1, 1, 1);
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 11) check_value("wd_before", hold_timeout, 1'b0);
    end
    check_value("wd_set", hold_timeout, 1'b1);
    bus_if.hold_request = 1'b0;
    repeat (3) step();
    check_value("wd_sticky", hold_timeout, 1'b1);
    clear_timeout = 1'b1;
    step();
    clear_timeout = 1'b0;
    check_value("wd_clear", hold_timeout, 1'b0);

    // Asynchronous reset in the middle of a tenure, with pages and flag set.
    set_bus(1, 1, 1);
    repeat (14) step();
    check_value("pre_rst_hlda", bus_if.hold_acknowledge, 1'b1);
    reset_pulse();
    step();

    // Randomised traffic.
    for (int n = 0; n < 800; n++) begin
      int r;
      if ($urandom_range(0, 7) == 0) bus_if.hold_request = ~bus_if.hold_request;
      bus_if.cpu_bus_idle = ($urandom_range(0, 3) != 0);
      bus_if.cpu_lock_n   = ($urandom_range(0, 5) != 0);
      page_write   = ($urandom_range(0, 3) == 0);
      page_select  = 2'($urandom_range(0, 3));
      page_data_in = PW'($urandom);
      r = $urandom_range(0, 5);
      if (r == 0)      bus_if.dma_acknowledge = 4'b0000;
      else if (r == 5) bus_if.dma_acknowledge = 4'($urandom);
      else             bus_if.dma_acknowledge = 4'(1 << (r - 1));
      clear_timeout = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 299) == 0) reset_pulse();
      else step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dma_bus_arbiter.md
# dma_bus_arbiter

Arbitrates the system bus between the CPU and the 8237-compatible DMA controller, and supplies the upper address bits of DMA transfers. It turns the DMA controller's hold request into a hold acknowledge only after the CPU has finished its current bus cycle and released the bus. It also holds the four channel page registers and drives the page of the acknowledged channel onto the upper address lines. A watchdog flags DMA bus tenures that run too long.

## Interface
- `PAGE_WIDTH`, 4: bits per page register (upper address bits above the DMA 16-bit address).
- `GRANT_DELAY`, 2: cycles between releasing the CPU bus and asserting hold acknowledge; legal range ≥1.
- `RELEASE_DELAY`, 1: cycles the CPU bus stays released after hold acknowledge drops; legal range ≥1.
- `TIMEOUT_WIDTH`, 16: width of the tenure watchdog counter.
- `MAX_HOLD`, 16'hFFFF: number of GRANTED cycles at which the timeout flag is raised.

Ports (name, direction, width, meaning):
- `clock` in 1: the single clock; all state is updated on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `hold_request` in 1: HRQ from the DMA controller.
- `hold_acknowledge` out 1: HLDA to the DMA controller.
- `cpu_bus_idle` in 1: high when the CPU is in T4/Ti, i.e. no bus cycle is in progress.
- `cpu_lock_n` in 1: CPU LOCK; while low, no grant is given.
- `cpu_bus_release` out 1: tri-states the CPU address/data/control drivers.
- `dma_acknowledge` in 4: DACK from the DMA controller, active high, normally one-hot.
- `page_write` in 1: one-cycle write strobe for a page register.
- `page_select` in 2: channel index for a page register write or read.
- `page_data_in` in PAGE_WIDTH: data written to the selected page register.
- `page_data_out` out PAGE_WIDTH: combinational readback of the page register at `page_select`.
- `dma_high_address` out PAGE_WIDTH: page of the acknowledged channel.
- `hold_timeout` out 1: sticky watchdog flag.
- `clear_timeout` in 1: synchronous clear of `hold_timeout`.

## Operation
The arbiter is a state machine with five states: IDLE, WAIT_CPU, SETTLE, GRANTED, RELEASE.

Transitions:
- IDLE: `hold_request`=1 → WAIT_CPU.
- WAIT_CPU:
  - `hold_request`=0 → IDLE. The bus is never released.
  - Otherwise, `cpu_bus_idle`=1 and `cpu_lock_n`=1 → SETTLE, and the delay counter is loaded with GRANT_DELAY.
- SETTLE:
  - The state lasts exactly GRANT_DELAY cycles, then → GRANTED.
  - `hold_request`=0 during SETTLE → RELEASE, and hold acknowledge is never asserted.
- GRANTED: `hold_request`=0 → RELEASE, and the delay counter is loaded with RELEASE_DELAY. Lock and idle are ignored in this state.
- RELEASE: the state lasts RELEASE_DELAY cycles, then → IDLE. A `hold_request` seen during RELEASE is only acted on from IDLE.

Output decodes:
- `cpu_bus_release` = state ∈ {SETTLE, GRANTED, RELEASE}.
- `hold_acknowledge` = state == GRANTED.
- Both outputs are derived from state registers, so they are glitch-free.

Page registers:
- Four registers of PAGE_WIDTH bits each.
- A write updates `page[page_select]` on the edge where `page_write`=1.
- The I/O port-to-channel mapping (0x83→1, 0x81→2, 0x82→3, 0x87→0) is decoded outside this block.
- `dma_high_address` = page of the lowest-index asserted `dma_acknowledge` bit; 0 if none is asserted.

Watchdog:
- The counter clears on entry to GRANTED and increments every GRANTED cycle, saturating at MAX_HOLD.
- On reaching MAX_HOLD, `hold_timeout` is set and stays set until `clear_timeout` or reset.
- If `clear_timeout` and the set condition occur in the same cycle, set wins.

Reset: asserting `reset_n` low at any time, including mid-transfer, puts the block in IDLE with every output and register at 0. In particular `hold_acknowledge`, `cpu_bus_release`, all page registers, the counters and `hold_timeout` are 0.

## Timing
- Call E0 the edge that samples `hold_request`=1 while the CPU is idle and unlocked. Then:
  - `cpu_bus_release` rises after E0+1.
  - `hold_acknowledge` rises after E0+1+GRANT_DELAY (E0+3 with the defaults).
- Each additional cycle of `cpu_bus_idle`=0 or `cpu_lock_n`=0 in WAIT_CPU adds one cycle to both figures.
- `hold_request` falling, sampled at edge Ef:
  - `hold_acknowledge` falls after Ef.
  - `cpu_bus_release` falls after Ef+RELEASE_DELAY.
- A page write is visible on `page_data_out` and `dma_high_address` after the write edge; there is no bypass in the write cycle.
- `page_data_out` and `dma_high_address` are combinational from the registers and inputs.

## Structure
- Package `dma_arbiter_pkg` holds the state enum (`arb_state_t`) and the default parameter constants.
- Sub-module `dma_page_registers` contains the four-entry page register file: write port, read mux and DACK select.
- The state machine, delay counter and watchdog sit in the top module.

## Test plan
- Reset, then `hold_request`=1 with `cpu_bus_idle`=1 and `cpu_lock_n`=1 → `cpu_bus_release`=1 after edge 2 and `hold_acknowledge`=1 after edge 4; both were 0 before.
- `cpu_bus_idle`=0 for 5 cycles, then 1 → `hold_acknowledge` is delayed by 5 cycles; `cpu_lock_n`=0 likewise blocks the grant.
- `hold_request` dropped in WAIT_CPU → `cpu_bus_release` never rises; dropped in SETTLE → `hold_acknowledge` never rises and the release lasts RELEASE_DELAY cycles.
- Write page 0xA to channel 2 and 0x5 to channel 3, then `dma_acknowledge`=4'b0100 → `dma_high_address`=0xA; with 4'b1000 → 0x5; with 4'b0000 → 0.
- MAX_HOLD=8 and GRANTED held for 8 cycles → `hold_timeout`=1 and stays 1 after release; `clear_timeout` → 0.
- `reset_n` pulsed low while GRANTED → `hold_acknowledge`, `cpu_bus_release`, page registers and `hold_timeout` go to 0 without waiting for a clock edge.
